// File: rtl/filter_coeff_ctrl.sv
// Filter coefficient controller for a state variable filter.
// Converts an octave/mantissa cutoff code into a 1.17 frequency coefficient F by
// shift-and-clamp, and a 4-bit resonance code into a 2.16 damping coefficient Q1.
// Optional feature macro: FILTER_COEFF_SLEW_EN -- when defined, F slews toward the
// computed target by at most SLEW_STEP per slew_tick; otherwise F jumps on LOAD.
module filter_coeff_ctrl #(
  parameter int unsigned F_MAX     = 72090,
  parameter int unsigned Q1_STEP   = 8192,
  parameter int unsigned SLEW_STEP = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         cutoff,
  input  logic [3:0]         resonance,
  input  logic               slew_tick,
  output logic signed [17:0] F,
  output logic signed [17:0] Q1,
  output logic               busy
);

  localparam int unsigned Q1_MAX  = 131071;
  localparam int unsigned F_RESET = 16;

  localparam logic [19:0] FMaxAcc = 20'(F_MAX);
  localparam logic [17:0] FMaxW   = 18'(F_MAX);
  localparam logic [17:0] FRstW   = 18'(F_RESET);
  localparam logic [17:0] Q1MaxW  = 18'(Q1_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StLoad
  } state_e;

  state_e      state_q;
  logic [19:0] acc_q;
  logic [3:0]  cnt_q;
  logic [3:0]  res_q;
  logic [17:0] f_target_q;
  logic [17:0] f_q;
  logic [17:0] q1_q;

  logic [17:0] f_load;
  logic [17:0] q1_load;
  logic [31:0] q1_full;
  logic        calc_done;

  // Handshake and status decode straight from the state register
  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);

  assign F  = f_q;
  assign Q1 = q1_q;

  // LOAD-time values: clamped accumulator and damping from the captured resonance
  always_comb begin
    f_load    = (acc_q > FMaxAcc) ? FMaxW : acc_q[17:0];
    q1_full   = Q1_MAX - (32'(res_q) * Q1_STEP);
    q1_load   = q1_full[17:0];
    // Stop shifting once the octave is exhausted or the value already exceeds the ceiling
    calc_done = (cnt_q == 4'd0) || (acc_q > FMaxAcc);
  end

`ifdef FILTER_COEFF_SLEW_EN
  localparam logic [17:0] SlewW = 18'(SLEW_STEP);

  logic [17:0] f_diff;
  logic [17:0] f_step;
  logic [17:0] f_slew;

  // Next F after one slew tick: move toward the current (pre-LOAD) target
  always_comb begin
    f_diff = '0;
    f_step = '0;
    f_slew = f_q;
    if (f_target_q > f_q) begin
      f_diff = f_target_q - f_q;
      f_step = (f_diff > SlewW) ? SlewW : f_diff;
      f_slew = f_q + f_step;
    end else if (f_target_q < f_q) begin
      f_diff = f_q - f_target_q;
      f_step = (f_diff > SlewW) ? SlewW : f_diff;
      f_slew = f_q - f_step;
    end
  end
`else
  logic unused_slew_tick;
  assign unused_slew_tick = slew_tick;
`endif

  // Control FSM with all coefficient registers; reset aborts any request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      f_target_q <= FRstW;
      f_q        <= FRstW;
      q1_q       <= Q1MaxW;
    end else begin
`ifdef FILTER_COEFF_SLEW_EN
      // Slewing runs in every state; f_slew was built from the old target
      if (slew_tick) begin
        f_q <= f_slew;
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            res_q   <= resonance;
            // 16 + m: implicit leading one above the 4-bit mantissa
            acc_q   <= {15'd0, 1'b1, cutoff[3:0]};
            cnt_q   <= cutoff[7:4];
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (calc_done) begin
            state_q <= StLoad;
          end else begin
            acc_q <= {acc_q[18:0], 1'b0};
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StLoad: begin
          f_target_q <= f_load;
          q1_q       <= q1_load;
`ifndef FILTER_COEFF_SLEW_EN
          f_q        <= f_load;
`endif
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_coeff_ctrl.sv
// Directed bench for filter_coeff_ctrl with a scoreboard of expected coefficient updates.
// Build with FILTER_COEFF_SLEW_EN defined to exercise the slewing variant.
module tb_filter_coeff_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [7:0]         cutoff;
  logic [3:0]         resonance;
  logic               slew_tick;
  logic signed [17:0] F;
  logic signed [17:0] Q1;
  logic               busy;

  always #5 clk = ~clk;

  filter_coeff_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .cutoff    (cutoff),
    .resonance (resonance),
    .slew_tick (slew_tick),
    .F         (F),
    .Q1        (Q1),
    .busy      (busy)
  );

  typedef struct {
    string tag;
    int    f;
    int    q1;
    int    lat;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int f_now  = 16;      // expected F
  int q1_now = 131071;  // expected Q1

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Issue one request, scribble inputs while busy, then pop and compare on completion
  task automatic do_req(input string tag, input logic [7:0] c, input logic [3:0] r,
                        input int exp_f, input int exp_q1, input int exp_lat);
    exp_t e;
    int   lat;
    @(negedge clk);
    check({tag, "_ready_before"}, req_ready, 1);
    cutoff    = c;
    resonance = r;
    req_valid = 1'b1;
    e.tag = tag;
`ifdef FILTER_COEFF_SLEW_EN
    e.f   = f_now;
`else
    e.f   = exp_f;
`endif
    e.q1  = exp_q1;
    e.lat = exp_lat;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (req_ready !== 1'b1 && lat < 100) begin
      lat++;
      check({tag, "_q1_hold"}, Q1, q1_now);
      check({tag, "_f_bound"}, (int'(F) <= 72090 && int'(F) >= 0) ? 1 : 0, 1);
      cutoff    = 8'($urandom);
      resonance = 4'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req_valid = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_latency"}, lat, e.lat);
    check({e.tag, "_q1"}, Q1, e.q1);
    check({e.tag, "_f"}, F, e.f);
    check({e.tag, "_busy_after"}, busy, 0);
    q1_now = e.q1;
    f_now  = e.f;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int up_seq[5];
    int dn_seq[5];
    up_seq = '{272, 528, 784, 832, 832};
    dn_seq = '{576, 320, 64, 16, 16};

    rst       = 1'b1;
    req_valid = 1'b0;
    cutoff    = 8'h00;
    resonance = 4'h0;
    slew_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_f", F, 16);
    check("rst_q1", Q1, 131071);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef FILTER_COEFF_SLEW_EN
    // Tick held through the request: the LOAD-edge tick still sees the old target
    slew_tick = 1'b1;
    do_req("slew_up", 8'h5A, 4'd4, 832, 98303, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("slew_up_step%0d", i), F, up_seq[i]);
    end
    slew_tick = 1'b0;
    f_now = 832;
    repeat (3) begin
      @(negedge clk);
      check("slew_hold_no_tick", F, f_now);
    end
    slew_tick = 1'b1;
    do_req("slew_dn", 8'h00, 4'd0, 16, 131071, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("slew_dn_step%0d", i), F, dn_seq[i]);
    end
    slew_tick = 1'b0;
    f_now = 16;
`endif

    do_req("min_code", 8'h00, 4'd0, 16, 131071, 2);
    do_req("mid_code", 8'h5A, 4'd4, 832, 98303, 7);
    do_req("clamp", 8'hFF, 4'd15, 72090, 8191, 14);
    do_req("oct4", 8'h4F, 4'd1, 496, 122879, 6);
    do_req("oct10", 8'hA3, 4'd7, 19456, 73727, 12);

    // Reset two cycles into CALC must abort without touching the coefficients
    @(negedge clk);
    cutoff    = 8'hA3;
    resonance = 4'd3;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_busy_pre", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_f", F, 16);
    check("abort_q1", Q1, 131071);
    check("abort_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst    = 1'b0;
    f_now  = 16;
    q1_now = 131071;
    repeat (15) @(negedge clk);
    check("abort_no_late_q1", Q1, 131071);
    check("abort_no_late_f", F, 16);

    do_req("after_abort", 8'hA3, 4'd2, 19456, 114687, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/filter_coeff_ctrl.md
FILTER_COEFF_CTRL -- requirements
Module: filter_coeff_ctrl

Interface
REQ-001 Parameter F_MAX, default 72090, meaning F clamp ceiling in 1.17 (about 0.55).
REQ-002 Parameter Q1_STEP, default 8192, meaning Q1 decrement per resonance unit in 2.16.
REQ-003 Parameter SLEW_STEP, default 256, meaning maximum F change per slew_tick in 1.17 LSBs.
REQ-004 Port clk  in  1  single clock; all state SHALL be updated on its posedge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port req_valid  in  1  coefficient update request.
REQ-007 Port req_ready  out  1  block can accept a request.
REQ-008 Port cutoff  in  8  [7:4] octave e (0..15), [3:0] mantissa m.
REQ-009 Port resonance  in  4  0 = Q1 of about 2.0, 15 = highest Q.
REQ-010 Port slew_tick  in  1  sample-rate strobe for F slewing.
REQ-011 Port F  out  signed 18  1.17 frequency coefficient for the state variable filter.
REQ-012 Port Q1  out  signed 18  2.16 damping coefficient (1/Q).
REQ-013 Port busy  out  1  high in CALC or LOAD.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and LOAD; req_ready SHALL equal (state==IDLE), and busy SHALL equal its inverse.
REQ-015 A request SHALL be accepted on an edge where req_valid and req_ready are both high; at acceptance, cutoff and resonance SHALL be captured, acc (20-bit unsigned) SHALL be loaded with 16+m, cnt SHALL be loaded with e, and state SHALL go to CALC.
REQ-016 In CALC, per edge: if cnt==0 or acc>F_MAX, go to LOAD; otherwise shift acc left by 1 and decrement cnt.
REQ-017 In LOAD: f_target SHALL be min(acc, F_MAX), Q1 SHALL be 131071 - res*Q1_STEP, and state SHALL return to IDLE.
REQ-018 Latency from the accept edge to updated f_target/Q1 SHALL be e+2 edges when no clamp occurs; an early clamp SHALL shorten it.
REQ-019 req_valid while busy SHALL be ignored; the sender holds the request until req_ready is high.
REQ-020 Captured cutoff/resonance SHALL be immune to input changes after acceptance.
REQ-021 F and Q1 SHALL always be non-negative, with F ≤ F_MAX and Q1 in 8191..131071.
REQ-022 Simultaneous slew_tick and LOAD: the slew SHALL use the pre-LOAD f_target.
REQ-023 slew_tick outside LOAD SHALL be honoured in any state, including IDLE, CALC and busy.

Reset
REQ-024 While rst is high: state SHALL be IDLE, F=16, f_target=16, Q1=131071, acc=0, cnt=0, req_ready=1, busy=0.
REQ-025 Reset asserted mid-CALC or mid-LOAD SHALL abort the computation without updating f_target or Q1 from the aborted request.

Configuration
REQ-026 Macro FILTER_COEFF_SLEW_EN, when defined: on each slew_tick with F≠f_target, F SHALL move toward f_target by min(SLEW_STEP, |f_target-F|); F SHALL be unchanged without slew_tick.
REQ-027 FILTER_COEFF_SLEW_EN undefined: F SHALL load f_target on the LOAD edge, slew_tick SHALL be ignored, and the SLEW_STEP logic SHALL be absent.

Verification
REQ-028 Reset, then cutoff=0x00, res=0, one-cycle valid -> F=16 and Q1=131071 two edges after accept, with ready low for exactly 2 cycles (slew off).
REQ-029 cutoff=0x5A, res=4 (slew off) -> F=832 and Q1=98303 exactly 7 edges after accept; busy high for 7 cycles.
REQ-030 cutoff=0xFF -> early clamp after 12 shifts, giving F=72090 at accept+14 instead of accept+17; F never exceeds 72090.
REQ-031 Slew on: F=16, request cutoff=0x5A, slew_tick every cycle from LOAD onward -> F sequence 272, 528, 784, 832, then holds.
REQ-032 Slew on: F reaches 832, then request cutoff=0x00 -> F steps 576, 320, 64, 16; changing cutoff while busy has no effect.
REQ-033 Assert rst two cycles into the CALC for cutoff=0xA3 -> immediately F=16, Q1=131071, ready=1; the next request completes normally.
